// File: rtl/inst_fetch_bridge.sv
// Instruction-fetch front end: turns pcF into one sram-like read per fetch,
// stalls the pipe while the fetch is in flight and buffers the word under stall.
module inst_fetch_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pcF,
  input  logic              stall_ext,
  input  logic              flush_except,
  output logic [DATA_W-1:0] instrF,
  output logic              stallreq_from_if,
  output logic              inst_req,
  output logic              inst_wr,
  output logic [1:0]        inst_size,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [DATA_W-1:0] inst_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] buf_q;
  logic              drop_q;
  logic              pc_misaligned;

  assign pc_misaligned = |pcF[1:0];

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      buf_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          addr_q <= pcF;
          if (!pc_misaligned && !flush_except) state_q <= S_REQ;
        end
        S_REQ: begin
          // An issued request cannot be retracted; a flush only marks its reply as junk.
          if (inst_addr_ok) begin
            state_q <= (flush_except || drop_q) ? S_DROP : S_WAIT;
            drop_q  <= 1'b0;
          end else if (flush_except) begin
            drop_q  <= 1'b1;
          end
        end
        S_WAIT: begin
          if (inst_data_ok) begin
            if (flush_except || !stall_ext) begin
              state_q <= S_IDLE;
            end else begin
              buf_q   <= inst_rdata;
              state_q <= S_HOLD;
            end
          end else if (flush_except) begin
            state_q <= S_DROP;
          end
        end
        S_HOLD: begin
          if (!stall_ext || flush_except) state_q <= S_IDLE;
        end
        S_DROP: begin
          if (inst_data_ok) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    instrF           = '0;
    stallreq_from_if = 1'b0;
    inst_req         = 1'b0;
    if (rst) begin
      case (state_q)
        S_IDLE: stallreq_from_if = !pc_misaligned;
        S_REQ: begin
          inst_req         = 1'b1;
          stallreq_from_if = 1'b1;
        end
        S_WAIT: begin
          instrF           = inst_rdata;
          stallreq_from_if = !inst_data_ok;
        end
        S_HOLD: instrF = buf_q;
        S_DROP: stallreq_from_if = 1'b1;
        default: ;
      endcase
    end
  end

  assign inst_wr   = 1'b0;
  assign inst_size = 2'b10;
  assign inst_addr = addr_q;

endmodule
